alu_arbiter: RTL
================

# alu_arbiter

Two-port round-robin arbiter and sequencer that shares the single 16-bit combinational shift ALU (3-bit op, operands a/b, result plus carry-out) between two requesters. Each requester hands over one operation with a valid/ready handshake. The block registers the operands, drives the ALU for one evaluate cycle and captures its result and carry, then holds the response until the owning requester accepts it. It also keeps a per-port count of completed operations.

## Interface
- No parameters. Data width is fixed at 16, op width at 3.
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid_0 / req_valid_1  in  1  requester k presents an operation
- req_ready_0 / req_ready_1  out  1  block accepts requester k's operation this cycle
- req_op_0 / req_op_1  in  3  ALU op code, passed through unmodified
- req_a_0 / req_a_1  in  16  operand a
- req_b_0 / req_b_1  in  16  operand b
- rsp_valid_0 / rsp_valid_1  out  1  result for requester k is available
- rsp_ready_0 / rsp_ready_1  in  1  requester k accepts the result
- rsp_data  out  16  captured ALU result, shared by both ports
- rsp_cout  out  1  captured ALU carry-out, shared by both ports
- alu_op  out  3  registered op driven to the ALU
- alu_a  out  16  registered operand a driven to the ALU
- alu_b  out  16  registered operand b driven to the ALU
- alu_y  in  16  ALU result, combinational from alu_op/alu_a/alu_b
- alu_cout  in  1  ALU carry-out
- done_cnt_0 / done_cnt_1  out  16  completed operations per port, wraps 0xFFFF to 0x0000

## Operation
- FSM states: IDLE, EXEC, DONE. `owner` (1 bit) records the port being served. `last` (1 bit) records the port served most recently.
- IDLE:
  - Winner when only one port is valid: that port.
  - Winner when both ports are valid: the port that is not `last`.
  - req_ready_k = (state==IDLE) && winner==k && req_valid_k.
  - On handshake: register op/a/b into alu_op/alu_a/alu_b, set owner to the winner, go to EXEC.
- EXEC: lasts exactly one cycle. At the end of the cycle, capture alu_y into rsp_data and alu_cout into rsp_cout, then go to DONE.
- DONE:
  - rsp_valid_owner = 1; the other rsp_valid is 0.
  - rsp_data, rsp_cout and alu_* stay stable until the response is accepted.
  - On rsp_ready_owner: go to IDLE, set last to owner, increment done_cnt_owner by 1 (modulo 2^16).
  - rsp_ready of the non-owner port is ignored.
- req_ready_0 and req_ready_1 are never both high. req_ready is 0 in EXEC and DONE regardless of req_valid.
- alu_op/alu_a/alu_b change only on an accepted request. Between operations they keep the last accepted values.
- Reset values:
  - state = IDLE, last = 1, so port 0 wins the first contention.
  - alu_op = 0, alu_a = 0, alu_b = 0, rsp_data = 0, rsp_cout = 0.
  - done_cnt_0 = 0, done_cnt_1 = 0.
  - All ready and valid outputs = 0.
- Reset during EXEC or DONE drops the transaction: no rsp_valid is produced and no counter increments.

## Timing
- req_ready is combinational from state, last and req_valid. All other outputs are registered.
- Request accepted at edge N, meaning req handshake high in the cycle before edge N:
  - alu_* valid from N.
  - rsp_data/rsp_cout captured at N+1.
  - rsp_valid high from N+1.
- Response accepted at edge M: rsp_valid low from M. The earliest next request accept is edge M+1.
- Minimum occupancy is 3 cycles per operation (IDLE, EXEC, DONE).
- rsp_ready may already be high when rsp_valid rises. The response then completes in a single DONE cycle.
- A requester must hold req_valid and its operands stable until it sees req_ready.

## Test plan
- Bench ALU model for all scenarios: {alu_cout, alu_y} = alu_a + alu_b, independent of op.
- Reset, then port 0 only, op=3'b000, a=16'hCB7F, b=16'h0013, rsp_ready_0 held high:
  - alu_a = CB7F one edge after accept.
  - rsp_valid_0 one edge later with rsp_data=16'hCB92, rsp_cout=0.
  - done_cnt_0 = 1; rsp_valid_1 never asserts.
- Port 1 only, a=16'hCB7F, b=16'h6FFF, op=3'b111:
  - alu_op = 3'b111.
  - rsp_data = 16'h3B7E, rsp_cout = 1.
  - done_cnt_1 increments.
- Both ports valid continuously, 4 operations:
  - Grants alternate 0, 1, 0, 1 immediately after reset.
  - req_ready is never high on both ports at once.
- Back-pressure: rsp_ready_0 low for 5 cycles:
  - rsp_valid_0, rsp_data and alu_* stay stable.
  - req_ready_1 stays 0 despite req_valid_1 = 1.
  - Port 1 is accepted one edge after the port-0 response handshake.
- rst_n asserted in DONE:
  - All outputs return to reset values immediately, asynchronously.
  - The pending response and counter increment are discarded.
  - After release, port 0 wins the first contention.
- Counter wrap: drive 65536 port-0 operations; done_cnt_0 reads 0x0000 after the last one.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response, shared-ALU and completion-counter signals of the two-port ALU arbiter.
// The arbiter takes the slave view, requesters the master view, the ALU the alu view.
interface alu_arbiter_if;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [2:0]  req_op_0, req_op_1;
  logic [15:0] req_a_0, req_a_1;
  logic [15:0] req_b_0, req_b_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0, rsp_ready_1;
  logic [15:0] rsp_data;
  logic        rsp_cout;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_y;
  logic        alu_cout;
  logic [15:0] done_cnt_0, done_cnt_1;

  modport slave (
    input  req_valid_0, req_valid_1, req_op_0, req_op_1,
           req_a_0, req_a_1, req_b_0, req_b_1,
           rsp_ready_0, rsp_ready_1, alu_y, alu_cout,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
           rsp_data, rsp_cout, alu_op, alu_a, alu_b,
           done_cnt_0, done_cnt_1
  );

  modport master (
    output req_valid_0, req_valid_1, req_op_0, req_op_1,
           req_a_0, req_a_1, req_b_0, req_b_1,
           rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
           rsp_data, rsp_cout, done_cnt_0, done_cnt_1
  );

  modport alu (
    input  alu_op, alu_a, alu_b,
    output alu_y, alu_cout
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter lending one combinational ALU to two requesters: accept, one
// evaluate cycle, then hold the captured result until the owning port takes it.
module alu_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nxt;
  logic   owner, last, winner, accept, rsp_ack;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    winner = 1'b0;
    if (bus.req_valid_0 && bus.req_valid_1) winner = ~last;
    else if (bus.req_valid_1)               winner = 1'b1;
  end

  assign bus.req_ready_0 = (state == IDLE) && !winner && bus.req_valid_0;
  assign bus.req_ready_1 = (state == IDLE) &&  winner && bus.req_valid_1;
  assign accept          = bus.req_ready_0 || bus.req_ready_1;
  // Only the owner's rsp_ready can retire the response.
  assign rsp_ack = (state == DONE) && (owner ? bus.rsp_ready_1 : bus.rsp_ready_0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)  state_nxt = EXEC;
      EXEC:                 state_nxt = DONE;
      DONE:    if (rsp_ack) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Operand registers feed the ALU and only move on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_op <= 3'd0;
      bus.alu_a  <= 16'd0;
      bus.alu_b  <= 16'd0;
      owner      <= 1'b0;
    end else if (accept) begin
      bus.alu_op <= winner ? bus.req_op_1 : bus.req_op_0;
      bus.alu_a  <= winner ? bus.req_a_1  : bus.req_a_0;
      bus.alu_b  <= winner ? bus.req_b_1  : bus.req_b_0;
      owner      <= winner;
    end
  end

  // last resets to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_data    <= 16'd0;
      bus.rsp_cout    <= 1'b0;
      bus.rsp_valid_0 <= 1'b0;
      bus.rsp_valid_1 <= 1'b0;
      bus.done_cnt_0  <= 16'd0;
      bus.done_cnt_1  <= 16'd0;
      last            <= 1'b1;
    end else if (state == EXEC) begin
      bus.rsp_data    <= bus.alu_y;
      bus.rsp_cout    <= bus.alu_cout;
      bus.rsp_valid_0 <= !owner;
      bus.rsp_valid_1 <= owner;
    end else if (rsp_ack) begin
      bus.rsp_valid_0 <= 1'b0;
      bus.rsp_valid_1 <= 1'b0;
      last            <= owner;
      if (owner) bus.done_cnt_1 <= bus.done_cnt_1 + 16'd1;
      else       bus.done_cnt_0 <= bus.done_cnt_0 + 16'd1;
    end
  end
endmodule
